// File: rtl/mul_rr_scheduler_pkg.sv
// Shared definitions for the multiplier round-robin scheduler.
//   - state_e : FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - OPW     : operand width handed to the Booth multiplier
//   - PRODW   : full product width returned by the multiplier
//   - next_index() : modulo-n successor used for the round-robin pointer
package mul_rr_scheduler_pkg;

  localparam int OPW   = 32;
  localparam int PRODW = 67;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mul_rr_scheduler_if.sv
// Bundle of every non-clock signal of the multiplier scheduler.
//   Requester side : req, x_in, y_in (in) / gnt (out)
//   Multiplier side: mul_done, mul_product (in) / mul_active, mul_x, mul_y (out)
//   Result side    : busy, res_valid, res_id, res_product, res_err (out)
// modport master : the scheduler's view (drives grants, multiplier start, results)
// modport slave  : the environment's view (requesters plus multiplier unit)
interface mul_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import mul_rr_scheduler_pkg::*;

  logic [NREQ-1:0]     req;
  logic [NREQ*OPW-1:0] x_in;
  logic [NREQ*OPW-1:0] y_in;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                mul_active;
  logic [OPW-1:0]      mul_x;
  logic [OPW-1:0]      mul_y;
  logic                mul_done;
  logic [PRODW-1:0]    mul_product;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [PRODW-1:0]    res_product;
  logic                res_err;

  modport master (
    input  req, x_in, y_in, mul_done, mul_product,
    output gnt, busy, mul_active, mul_x, mul_y,
           res_valid, res_id, res_product, res_err
  );

  modport slave (
    output req, x_in, y_in, mul_done, mul_product,
    input  gnt, busy, mul_active, mul_x, mul_y,
           res_valid, res_id, res_product, res_err
  );

endinterface

// File: rtl/mul_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req : per-requester request bits
//   i_ptr : requester with highest priority this cycle
//   o_gnt : one-hot winner (all zero when no request)
//   o_idx : encoded winner index
//   o_any : at least one request present
module mul_rr_scheduler_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Walk ptr, ptr+1, ... mod NREQ; the first set bit wins.
  always_comb begin
    int c;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    for (int i = 0; i < NREQ; i++) begin
      c = (int'(i_ptr) + i) % NREQ;
      if (!o_any && i_req[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one 32x32 signed Booth multiplier between NREQ requesters.
// Round-robin grant, operand latch, start/done sequencing with a watchdog,
// and a tagged 67-bit result register.
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : mul_rr_scheduler_if.master (requests, multiplier handshake, results)
// NREQ must be 2..8, IDW = clog2(NREQ), TIMEOUT >= 40.
module mul_rr_scheduler
  import mul_rr_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  mul_rr_scheduler_if.master bus
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e                  r_state;
  state_e                  w_next;
  logic [IDW-1:0]          r_ptr;
  logic [IDW-1:0]          r_cur_id;
  logic [TW-1:0]           r_timer;
  logic signed [OPW-1:0]   r_mul_x;
  logic signed [OPW-1:0]   r_mul_y;
  logic signed [PRODW-1:0] r_res_product;
  logic [IDW-1:0]          r_res_id;
  logic                    r_res_err;

  logic [NREQ-1:0]         w_arb_gnt;
  logic [IDW-1:0]          w_arb_idx;
  logic                    w_arb_any;
  logic                    w_grant;
  logic                    w_done_take;
  logic                    w_timeout;

  mul_rr_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_grant = (r_state == ST_IDLE) && w_arb_any;

  // The timer is zero only in the first WAIT cycle, so it doubles as the
  // mask for a done flag left high by the previous multiply.
  assign w_done_take = (r_state == ST_WAIT) && bus.mul_done && (r_timer != '0);
  // Done has priority over the watchdog when both land in the same cycle.
  assign w_timeout   = (r_state == ST_WAIT) && !w_done_take && (r_timer == TLAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_any) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_done_take || w_timeout) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt        = '0;
    bus.busy       = 1'b1;
    bus.mul_active = 1'b0;
    bus.res_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.gnt  = w_arb_gnt;
        bus.busy = 1'b0;
      end
      ST_ISSUE: bus.mul_active = 1'b1;
      ST_WAIT:  bus.mul_active = 1'b1;
      ST_RESP:  bus.res_valid  = 1'b1;
      default:  bus.busy       = 1'b1;
    endcase
  end

  // Operand latch and pointer advance happen on the grant edge; operands
  // then stay frozen until the next grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr    <= '0;
      r_cur_id <= '0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
    end else if (w_grant) begin
      r_ptr    <= IDW'(next_index(int'(w_arb_idx), NREQ));
      r_cur_id <= w_arb_idx;
      r_mul_x  <= bus.x_in[int'(w_arb_idx)*OPW +: OPW];
      r_mul_y  <= bus.y_in[int'(w_arb_idx)*OPW +: OPW];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_timer <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_timer <= '0;
    end else if ((r_state == ST_WAIT) && !w_done_take && !w_timeout) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Result register: written once per operation, held until the next one.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_res_product <= '0;
      r_res_id      <= '0;
      r_res_err     <= 1'b0;
    end else if (w_done_take) begin
      r_res_product <= bus.mul_product;
      r_res_id      <= r_cur_id;
      r_res_err     <= 1'b0;
    end else if (w_timeout) begin
      r_res_product <= '0;
      r_res_id      <= r_cur_id;
      r_res_err     <= 1'b1;
    end
  end

  assign bus.mul_x       = r_mul_x;
  assign bus.mul_y       = r_mul_y;
  assign bus.res_product = r_res_product;
  assign bus.res_id      = r_res_id;
  assign bus.res_err     = r_res_err;

endmodule
